// File: rtl/mem_subsys.sv
// mem_subsys: shared single-port word RAM behind an instruction-fetch port and
// a data port, with a fixed number of wait states per access.
//
// The data port has priority. A granted access runs IDLE -> BUSY -> RESP.
// BUSY holds for WAIT_STATES extra cycles. The RAM is touched on the edge that
// leaves BUSY. The granted port's valid is high for the single RESP cycle.
// pause is asserted while any request is still waiting for its completion.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   i_req/i_addr       fetch request (held until i_valid), byte address
//   i_rdata/i_valid    fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr  data request (held until d_valid), write flag, byte address
//   d_wdata/d_be       write data and byte strobes
//   d_rdata/d_valid    read (or merged write-back) word, one-cycle completion pulse
//   i_err/d_err        only with MEM_SUBSYS_ERR_EN: access was out of range/misaligned
//   pause              core stall request
//
// Optional feature macro: MEM_SUBSYS_ERR_EN.
// When it is undefined, addresses wrap modulo the RAM depth and bits [1:0] are
// ignored. When it is defined, out-of-range or misaligned accesses are flagged.
// Flagged writes are dropped, and flagged reads return 0.
module mem_subsys #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [31:0]         i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_valid,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [31:0]         d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
`ifdef MEM_SUBSYS_ERR_EN
   output logic                i_err,
   output logic                d_err,
`endif
   output logic                pause
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    port_dat_q, port_dat_d;   // 1 = data port owns the access
   logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [BE_W-1:0]         be_q, be_d;
   logic                    i_valid_q, i_valid_d;
   logic                    d_valid_q, d_valid_d;
   logic [DATA_W-1:0]       i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]       d_rdata_q, d_rdata_d;

   logic [DATA_W-1:0]       ram [DEPTH];
   logic [DATA_W-1:0]       ram_rdata;
   logic [DATA_W-1:0]       ram_wdata;
   logic                    ram_we;
   logic                    acc_err;

   // Address bits outside the word index do not select a RAM word.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:DEPTH_LOG2+2], i_addr[1:0],
                               d_addr[31:DEPTH_LOG2+2], d_addr[1:0]};

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int k = 0; k < BE_W; k++) begin
         if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
      end
      return r;
   endfunction

`ifdef MEM_SUBSYS_ERR_EN
   logic err_q, err_d;
   logic i_err_q, i_err_d;
   logic d_err_q, d_err_d;

   function automatic logic addr_bad(input logic [31:0] a);
      return ((a >> (DEPTH_LOG2 + 2)) != 32'd0) || (a[1:0] != 2'b00);
   endfunction

   assign acc_err = err_q;
   assign i_err   = i_err_q;
   assign d_err   = d_err_q;
`else
   assign acc_err = 1'b0;
`endif

   assign ram_rdata = ram[addr_q];
   assign ram_wdata = merge_bytes(ram_rdata, wdata_q, be_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      port_dat_d = port_dat_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      i_valid_d  = 1'b0;
      d_valid_d  = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      ram_we     = 1'b0;
`ifdef MEM_SUBSYS_ERR_EN
      err_d      = err_q;
      i_err_d    = 1'b0;
      d_err_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (d_req) begin
               port_dat_d = 1'b1;
               addr_d     = d_addr[DEPTH_LOG2+1:2];
               we_d       = d_we;
               wdata_d    = d_wdata;
               be_d       = d_be;
               cnt_d      = 4'(WAIT_STATES);
               state_d    = BUSY;
`ifdef MEM_SUBSYS_ERR_EN
               err_d      = addr_bad(d_addr);
`endif
            end else if (i_req) begin
               port_dat_d = 1'b0;
               addr_d     = i_addr[DEPTH_LOG2+1:2];
               we_d       = 1'b0;
               wdata_d    = '0;
               be_d       = '0;
               cnt_d      = 4'(WAIT_STATES);
               state_d    = BUSY;
`ifdef MEM_SUBSYS_ERR_EN
               err_d      = addr_bad(i_addr);
`endif
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               if (port_dat_q) begin
                  d_valid_d = 1'b1;
                  // A write reports the merged word it leaves behind.
                  if (we_q) begin
                     ram_we    = ~acc_err;
                     d_rdata_d = acc_err ? '0 : ram_wdata;
                  end else begin
                     d_rdata_d = acc_err ? '0 : ram_rdata;
                  end
`ifdef MEM_SUBSYS_ERR_EN
                  d_err_d = err_q;
`endif
               end else begin
                  i_valid_d = 1'b1;
                  i_rdata_d = acc_err ? '0 : ram_rdata;
`ifdef MEM_SUBSYS_ERR_EN
                  i_err_d = err_q;
`endif
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         port_dat_q <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         i_valid_q  <= 1'b0;
         d_valid_q  <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
`ifdef MEM_SUBSYS_ERR_EN
         err_q      <= 1'b0;
         i_err_q    <= 1'b0;
         d_err_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         port_dat_q <= port_dat_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         i_valid_q  <= i_valid_d;
         d_valid_q  <= d_valid_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef MEM_SUBSYS_ERR_EN
         err_q      <= err_d;
         i_err_q    <= i_err_d;
         d_err_q    <= d_err_d;
`endif
      end
   end

   // RAM contents survive reset. An aborted access never reaches this write
   // because reset forces the FSM back to IDLE.
   always_ff @(posedge clk) begin
      if (ram_we && !reset) ram[addr_q] <= ram_wdata;
   end

   assign i_valid = i_valid_q;
   assign d_valid = d_valid_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign pause   = (i_req & ~i_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_subsys.sv
module tb_mem_subsys;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: WAIT_STATES=1
   logic        a_i_req, a_d_req, a_d_we;
   logic [31:0] a_i_addr, a_d_addr, a_d_wdata, a_i_rdata, a_d_rdata;
   logic [3:0]  a_d_be;
   logic        a_i_valid, a_d_valid, a_pause;
   // Instance B: WAIT_STATES=0
   logic        b_i_req, b_d_req, b_d_we;
   logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata;
   logic [3:0]  b_d_be;
   logic        b_i_valid, b_d_valid, b_pause;
`ifdef MEM_SUBSYS_ERR_EN
   logic        a_i_err, a_d_err, b_i_err, b_d_err;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   mem_subsys #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_STATES(1)) u_a (
      .clk(clk), .reset(reset),
      .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_valid(a_i_valid),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_be(a_d_be), .d_rdata(a_d_rdata), .d_valid(a_d_valid),
`ifdef MEM_SUBSYS_ERR_EN
      .i_err(a_i_err), .d_err(a_d_err),
`endif
      .pause(a_pause));

   mem_subsys #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_b (
      .clk(clk), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_valid(b_i_valid),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_be(b_d_be), .d_rdata(b_d_rdata), .d_valid(b_d_valid),
`ifdef MEM_SUBSYS_ERR_EN
      .i_err(b_i_err), .d_err(b_d_err),
`endif
      .pause(b_pause));

   // One data access on instance A: returns data, latency in cycles from the
   // request cycle, whether pause stayed high while waiting, pause in the valid cycle.
   task automatic a_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output int lat,
                         output logic pause_hi, output logic pause_v, output logic err);
      @(negedge clk);
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata; a_d_be = be;
      lat = 0; pause_hi = 1'b1;
      #1;
      while (!a_d_valid && lat < 40) begin
         if (!a_pause) pause_hi = 1'b0;
         @(posedge clk); @(negedge clk); #1; lat++;
      end
      rdata = a_d_rdata; pause_v = a_pause;
`ifdef MEM_SUBSYS_ERR_EN
      err = a_d_err;
`else
      err = 1'b0;
`endif
      a_d_req = 1'b0; a_d_we = 1'b0;
   endtask

   task automatic b_write(input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      @(negedge clk);
      b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = addr; b_d_wdata = wdata; b_d_be = 4'hF;
      n = 0; #1;
      while (!b_d_valid && n < 40) begin
         @(posedge clk); @(negedge clk); #1; n++;
      end
      n_chk++;
      if (b_d_valid !== 1'b1) $display("FAIL b_preload addr %h valid %b want 1", addr, b_d_valid);
      else n_pass++;
      b_d_req = 1'b0; b_d_we = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_chk++;
      if ({a_i_valid, a_d_valid, a_pause, b_i_valid, b_d_valid, b_pause} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000",
                  {a_i_valid, a_d_valid, a_pause, b_i_valid, b_d_valid, b_pause});
      else n_pass++;
      n_chk++;
      if ({a_i_rdata, a_d_rdata} !== 64'h0)
         $display("FAIL reset_rdata got %h want 0", {a_i_rdata, a_d_rdata});
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_write_read();
      logic [31:0] rd, ex; int lat; logic ph, pv, er;
      exp_q.push_back(32'hDEADBEEF);
      a_data(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL wr10_wb got %h want %h", rd, ex); else n_pass++;
      n_chk++;
      if ({lat, ph, pv} !== {32'd3, 1'b1, 1'b0})
         $display("FAIL wr10_timing lat/pause got %0d/%b/%b want 3/1/0", lat, ph, pv);
      else n_pass++;
      exp_q.push_back(32'hDEADBEEF);
      a_data(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL rd10 got %h want %h", rd, ex); else n_pass++;
      n_chk++;
      if ({lat, ph, pv} !== {32'd3, 1'b1, 1'b0})
         $display("FAIL rd10_timing lat/pause got %0d/%b/%b want 3/1/0", lat, ph, pv);
      else n_pass++;
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd, ex; int lat; logic ph, pv, er;
      exp_q.push_back(32'hDE22BE44);
      a_data(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL be0101_wb got %h want %h", rd, ex); else n_pass++;
      exp_q.push_back(32'hDE22BE44);
      a_data(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL be0101_rd got %h want %h", rd, ex); else n_pass++;
      // d_be=0 leaves the word untouched
      exp_q.push_back(32'hDE22BE44);
      a_data(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL be0_wb got %h want %h", rd, ex); else n_pass++;
      exp_q.push_back(32'hDE22BE44);
      a_data(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL be0_rd got %h want %h", rd, ex); else n_pass++;
   endtask

   task automatic test_collision();
      logic [31:0] rd, ex, dr, ir; int lat, t, td, ti; logic ph, pv, er, ph_all;
      a_data(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, lat, ph, pv, er);
      exp_q.push_back(32'hDE22BE44);   // data completes first
      exp_q.push_back(32'hCAFEF00D);   // then the fetch
      @(negedge clk);
      a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h10;
      a_i_req = 1'b1; a_i_addr = 32'h0;
      t = 0; td = -1; ti = -1; ph_all = 1'b1; dr = '0; ir = '0;
      #1;
      while (ti < 0 && t < 40) begin
         if (!a_pause) ph_all = 1'b0;
         @(posedge clk); @(negedge clk); #1; t++;
         if (a_d_valid) begin td = t; dr = a_d_rdata; a_d_req = 1'b0; end
         if (a_i_valid) begin ti = t; ir = a_i_rdata; a_i_req = 1'b0; end
      end
      a_d_req = 1'b0; a_i_req = 1'b0;
      ex = exp_q.pop_front();
      n_chk++; if (dr !== ex) $display("FAIL coll_d_data got %h want %h", dr, ex); else n_pass++;
      ex = exp_q.pop_front();
      n_chk++; if (ir !== ex) $display("FAIL coll_i_data got %h want %h", ir, ex); else n_pass++;
      n_chk++;
      if ({td, ti} !== {32'd3, 32'd7})
         $display("FAIL coll_order d/i cycle got %0d/%0d want 3/7", td, ti);
      else n_pass++;
      n_chk++;
      if ({ph_all, a_pause} !== 2'b10)
         $display("FAIL coll_pause held/after got %b/%b want 1/0", ph_all, a_pause);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      logic [31:0] ex;
      int t, k;
      int tv [3];
      words[0] = 32'h0A0A0001; words[1] = 32'h0B0B0002; words[2] = 32'h0C0C0003;
      for (int j = 0; j < 3; j++) b_write(32'(j * 4), words[j]);
      for (int j = 0; j < 3; j++) exp_q.push_back(words[j]);
      for (int j = 0; j < 3; j++) tv[j] = -1;
      @(negedge clk);
      b_i_req = 1'b1; b_i_addr = 32'h0; t = 0; k = 0;
      #1;
      while (k < 3 && t < 60) begin
         @(posedge clk); @(negedge clk); #1; t++;
         if (b_i_valid) begin
            ex = exp_q.pop_front(); tv[k] = t;
            n_chk++;
            if (b_i_rdata !== ex) $display("FAIL b2b_data%0d got %h want %h", k, b_i_rdata, ex);
            else n_pass++;
            k++;
            if (k < 3) b_i_addr = 32'(k * 4);
            else b_i_req = 1'b0;
         end
      end
      b_i_req = 1'b0;
      n_chk++;
      if ({tv[0], tv[1], tv[2]} !== {32'd2, 32'd5, 32'd8})
         $display("FAIL b2b_spacing got %0d,%0d,%0d want 2,5,8", tv[0], tv[1], tv[2]);
      else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] rd, ex; int lat; logic ph, pv, er;
      exp_q.push_back(32'h55AA55AA);
      a_data(1'b1, 32'h20, 32'h55AA55AA, 4'hF, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL wr20_wb got %h want %h", rd, ex); else n_pass++;
      @(negedge clk);
      a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'h12345678; a_d_be = 4'hF;
      @(posedge clk); @(negedge clk);   // granted, now in BUSY
      reset = 1'b1; a_d_req = 1'b0; a_d_we = 1'b0;
      #1;
      n_chk++;
      if ({a_d_valid, a_i_valid, a_pause, a_d_rdata} !== {3'b000, 32'h0})
         $display("FAIL midreset_async got v=%b%b p=%b rdata=%h want 000 0",
                  a_d_valid, a_i_valid, a_pause, a_d_rdata);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      exp_q.push_back(32'h55AA55AA);
      a_data(1'b0, 32'h20, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL midreset_rd20 got %h want %h", rd, ex); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] rd, ex; int lat; logic ph, pv, er;
`ifdef MEM_SUBSYS_ERR_EN
      exp_q.push_back(32'h0);          // suppressed write reports 0
      a_data(1'b1, 32'h1000, 32'h76543210, 4'hF, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++;
      if ({er, rd} !== {1'b1, ex}) $display("FAIL wrap_err_wr got err=%b %h want 1 %h", er, rd, ex);
      else n_pass++;
      n_chk++; if (lat !== 3) $display("FAIL wrap_err_lat got %0d want 3", lat); else n_pass++;
      exp_q.push_back(32'hCAFEF00D);   // word 0 unchanged
      a_data(1'b0, 32'h0, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++;
      if ({er, rd} !== {1'b0, ex}) $display("FAIL wrap_err_rd0 got err=%b %h want 0 %h", er, rd, ex);
      else n_pass++;
      exp_q.push_back(32'h0);          // misaligned read flagged, data 0
      a_data(1'b0, 32'h11, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++;
      if ({er, rd} !== {1'b1, ex}) $display("FAIL misalign_err got err=%b %h want 1 %h", er, rd, ex);
      else n_pass++;
`else
      exp_q.push_back(32'h76543210);
      a_data(1'b1, 32'h1000, 32'h76543210, 4'hF, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL wrap_wr got %h want %h", rd, ex); else n_pass++;
      exp_q.push_back(32'h76543210);   // 0x1000 aliases word 0
      a_data(1'b0, 32'h0, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL wrap_rd0 got %h want %h", rd, ex); else n_pass++;
      exp_q.push_back(32'hDE22BE44);   // 0x11 reads word 0x10
      a_data(1'b0, 32'h11, 32'h0, 4'h0, rd, lat, ph, pv, er);
      ex = exp_q.pop_front();
      n_chk++; if (rd !== ex) $display("FAIL misalign_rd got %h want %h", rd, ex); else n_pass++;
`endif
   endtask

   initial begin
      reset = 1'b1;
      a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
      a_d_addr = '0; a_d_wdata = '0; a_d_be = '0;
      b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
      b_d_addr = '0; b_d_wdata = '0; b_d_be = '0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_reset_midop();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
